vga_tile_renderer: RTL
======================

# vga_tile_renderer

- Parametrised successor to the fixed 40×40 snake-board VGA controller.
- Generates VGA sync internally and scans a tile board held in an external synchronous RAM, one read per pixel.
- Maps each cell value to a fixed colour and draws a border column and a background.
- Sits between the game-logic board RAM and the DAC pins; replaces the wide board register and per-pixel divide/modulo.

## Interface

- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths
- TILE_PX, 12, pixel edge of one square tile
- COLS / ROWS, 40 / 40, board dimensions in tiles; COLS*TILE_PX < H_ACTIVE and ROWS*TILE_PX <= V_ACTIVE
- CELL_W, 2, bits per board cell
- ADDR_W, 11, board address width; 2^ADDR_W >= COLS*ROWS

Ports:

- iVGA_CLK  in  1  pixel clock
- iRST  in  1  reset; one clock, synchronous, active-high
- oBoardAddr  out  ADDR_W  cell address = row*COLS + col, registered
- iBoardData  in  CELL_W  cell value, valid exactly one cycle after oBoardAddr
- oHS  out  1  horizontal sync, active low
- oVS  out  1  vertical sync, active low
- oBLANK_n  out  1  high during visible pixels
- r_data / g_data / b_data  out  8 each  pixel colour
- oFrameStart  out  1  one-cycle pulse at the first output cycle of line V_ACTIVE, pixel 0

## Operation

- Stage 0: hc counts 0..H_TOTAL-1 (H_TOTAL = sum of H params); vc increments when hc wraps, range 0..V_TOTAL-1, and wraps to 0.
- Tile position is tracked incrementally; no runtime divider or multiplier:
  - px_x counts 0..TILE_PX-1 while hc < COLS*TILE_PX; tile_col increments on px_x wrap.
  - px_x and tile_col clear at hc wrap.
  - px_y and tile_row advance at line end; row_base += COLS on tile_row advance.
  - All clear at frame wrap.
- Stage 1: oBoardAddr <= row_base + tile_col when in the board region, else holds its last value.
- Stage 2: iBoardData is captured.
- Stage 3: the colour is selected and registered.
- Colour priority, first match wins:
  1. blank → 0x000000.
  2. hc == COLS*TILE_PX with vc < ROWS*TILE_PX → border, 0xFFFFFF.
  3. Outside the board → background, 0x404040.
  4. Otherwise by cell value: 0 → 0x000000; 1 → 0x00FF00 (snake 1); 2 → 0x0000FF (snake 2); 3 → 0xFF0000 (apple); ≥4 → 0xFF00FF.
- Region, sync and blank flags are computed at stage 0 and carried in a 3-deep pipeline alongside the data.
- Sync decode: HS low for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC; VS uses the same rule on vc; blank high for hc < H_ACTIVE and vc < V_ACTIVE.
- Reset: all counters 0; pipeline cleared to the blank state.

## Timing

- Output latency from the stage-0 counter value to the pins is 3 cycles, identical for colour, oHS, oVS, oBLANK_n and oFrameStart.
- Board RAM contract: read latency is exactly 1 cycle; no stall, no handshake.
- Reset values: oHS=1, oVS=1, oBLANK_n=0, rgb=0, oBoardAddr=0, oFrameStart=0.
  - Held while iRST is high and for the 3 cycles after it falls.
  - First output corresponds to hc=0, vc=0.
- iRST asserted mid-frame: on the next edge, counters return to 0 and the pipeline clears; no partial sync pulse is extended.
- Boundary conditions:
  - Last board pixel (hc = COLS*TILE_PX-1) uses tile_col = COLS-1.
  - Tile state does not advance outside the board region.
  - Line and frame wrap occur on the same edge at (H_TOTAL-1, V_TOTAL-1).

## Configuration

- RENDER_GRID_EN defined: inside the board, pixels with px_x==0 or px_y==0 render grid colour 0x202020, overriding the cell colour. Border and background are unaffected.
- RENDER_GRID_EN undefined: no grid; cell colour fills the whole tile. Latency is unchanged in both builds.

## Test plan

- Reset: hold iRST 5 cycles, release → outputs at reset values for exactly 3 more cycles, then blank=1 with colour from cell address 0.
- Sync: free-run 2 frames → HS period 800 cycles with 96 low; VS period 525 lines with 2 low; oFrameStart once per 420000 cycles.
- Address scan, line 0: oBoardAddr = 0 for 12 cycles, then 1 … 39; on line 12, starts at 40.
- Cell render: RAM model returns 1 only at address 410 → green at x 120..131, y 120..131 (output-aligned); black elsewhere on the board.
- Border/background: x=480, y<480 → 0xFFFFFF; x=481..639 → 0x404040; porch cycles → rgb 0 and oBLANK_n=0.
- Mid-frame reset at vc=200, hc=300 → next edge counters 0; the following frame is identical to the post-reset frame.
- With RENDER_GRID_EN: pixel (120,120) → 0x202020; pixel (121,121) → 0x00FF00.

Source files
------------

// File: rtl/vga_tile_renderer.sv
// Tile-board VGA renderer: sync generation, board RAM scan, colour map.
// Define RENDER_GRID_EN to draw a grid line on each tile's first row/column.
module vga_tile_renderer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int TILE_PX  = 12,
  parameter int COLS     = 40,
  parameter int ROWS     = 40,
  parameter int CELL_W   = 2,
  parameter int ADDR_W   = 11
) (
  input  logic              iVGA_CLK,
  input  logic              iRST,
  output logic [ADDR_W-1:0] oBoardAddr,
  input  logic [CELL_W-1:0] iBoardData,
  output logic              oHS,
  output logic              oVS,
  output logic              oBLANK_n,
  output logic [7:0]        r_data,
  output logic [7:0]        g_data,
  output logic [7:0]        b_data,
  output logic              oFrameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = (TILE_PX > 1) ? $clog2(TILE_PX) : 1;
  localparam int TW = $clog2(COLS + 1);
  localparam int RW = $clog2(ROWS + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] BRD_W  = HW'(COLS * TILE_PX);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] BRD_H  = VW'(ROWS * TILE_PX);
  localparam logic [XW-1:0] PX_LAST = XW'(TILE_PX - 1);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
    logic brd;
    logic bdr;
    logic grid;
    logic frm;
  } flags_t;

  localparam flags_t IDLE = '{hs: 1'b1, vs: 1'b1, default: 1'b0};

  logic [HW-1:0]     hc;
  logic [VW-1:0]     vc;
  logic [XW-1:0]     pxX;
  logic [XW-1:0]     pxY;
  logic [TW-1:0]     tileCol;
  logic [RW-1:0]     tileRow;
  logic [ADDR_W-1:0] rowBase;
  flags_t            f0, s1, s2;
  logic [23:0]       rgb;
  logic              lineEnd, frameEnd, inBoardH, inBoardV;

  assign lineEnd  = (hc == H_LAST);
  assign frameEnd = lineEnd && (vc == V_LAST);
  assign inBoardH = (hc < BRD_W);
  assign inBoardV = (vc < BRD_H);

  // Stage 0: raster counters plus incremental tile position.
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      hc      <= '0;
      vc      <= '0;
      pxX     <= '0;
      pxY     <= '0;
      tileCol <= '0;
      tileRow <= '0;
      rowBase <= '0;
    end else if (lineEnd) begin
      hc      <= '0;
      pxX     <= '0;
      tileCol <= '0;
      if (frameEnd) begin
        vc      <= '0;
        pxY     <= '0;
        tileRow <= '0;
        rowBase <= '0;
      end else begin
        vc <= vc + 1'b1;
        if (inBoardV) begin
          if (pxY == PX_LAST) begin
            pxY     <= '0;
            tileRow <= tileRow + 1'b1;
            rowBase <= rowBase + COLS_A;
          end else begin
            pxY <= pxY + 1'b1;
          end
        end
      end
    end else begin
      hc <= hc + 1'b1;
      if (inBoardH) begin
        if (pxX == PX_LAST) begin
          pxX     <= '0;
          tileCol <= tileCol + 1'b1;
        end else begin
          pxX <= pxX + 1'b1;
        end
      end
    end
  end

  // Stage 0 decode of sync, blank, region and frame-start flags.
  always_comb begin
    f0     = IDLE;
    f0.hs  = !((hc >= H_SS) && (hc < H_SE));
    f0.vs  = !((vc >= V_SS) && (vc < V_SE));
    f0.vis = (hc < H_VIS) && (vc < V_VIS);
    f0.brd = inBoardH && inBoardV;
    f0.bdr = (hc == BRD_W) && inBoardV;
`ifdef RENDER_GRID_EN
    f0.grid = (pxX == '0) || (pxY == '0);
`else
    f0.grid = 1'b0;
`endif
    f0.frm = (hc == '0) && (vc == V_VIS);
  end

  // Stages 1-2: issue the board read and carry flags alongside it.
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      oBoardAddr <= '0;
      s1         <= IDLE;
      s2         <= IDLE;
    end else begin
      if (f0.brd) oBoardAddr <= rowBase + ADDR_W'(tileCol);
      s1 <= f0;
      s2 <= s1;
    end
  end

  // Colour select from the cell value arriving with stage 2.
  always_comb begin
    rgb = 24'h000000;
    if (!s2.vis)       rgb = 24'h000000;
    else if (s2.bdr)   rgb = 24'hFFFFFF;
    else if (!s2.brd)  rgb = 24'h404040;
    else if (s2.grid)  rgb = 24'h202020;
    else begin
      case (iBoardData)
        CELL_W'(0): rgb = 24'h000000;
        CELL_W'(1): rgb = 24'h00FF00;
        CELL_W'(2): rgb = 24'h0000FF;
        CELL_W'(3): rgb = 24'hFF0000;
        default:    rgb = 24'hFF00FF;
      endcase
    end
  end

  // Stage 3: output registers.
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      oHS         <= 1'b1;
      oVS         <= 1'b1;
      oBLANK_n    <= 1'b0;
      oFrameStart <= 1'b0;
      r_data      <= '0;
      g_data      <= '0;
      b_data      <= '0;
    end else begin
      oHS         <= s2.hs;
      oVS         <= s2.vs;
      oBLANK_n    <= s2.vis;
      oFrameStart <= s2.frm;
      {r_data, g_data, b_data} <= rgb;
    end
  end

endmodule
